// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data requester. Only one memory transaction is outstanding at a time.
// Data has priority over fetch unless fetch has already waited through
// STARVE_MAX consecutive data grants.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 fetch read request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata      fetch accept strobe and read response
//   d_req/d_we/d_addr/d_wdata/d_wmask  data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata         data accept strobe and response/ack
//   m_valid/m_we/m_addr/m_wdata/m_wmask, m_ready  registered memory request
//   m_rvalid/m_rdata               memory response
//   hold_if                        stall for the fetch stage
//   err                            sticky protocol error (response before accept)
//
// State table:
//   S_IDLE     | no transaction; arbitrate and grant in the same cycle
//   S_WAIT_ACC | m_valid asserted, waiting for m_ready
//   S_WAIT_RSP | request accepted, waiting for m_rvalid

module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_valid,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wmask,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                hold_if,
  output logic                err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACC = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                own_if_q, own_if_d;   // 1 = fetch owns the transaction
  logic                m_valid_q, m_valid_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [MASK_W-1:0]   m_wmask_q, m_wmask_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                err_q, err_d;
  logic                pick_if;

  always_comb begin
    state_d   = state_q;
    own_if_d  = own_if_q;
    m_valid_d = m_valid_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wmask_d = m_wmask_q;
    starve_d  = starve_q;
    err_d     = err_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    // fetch wins only when data is absent or fetch has been starved long enough
    pick_if   = if_req && (!d_req || (starve_q == STARVE_LIM));

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          m_valid_d = 1'b1;
          state_d   = S_WAIT_ACC;
          if (pick_if) begin
            if_gnt    = 1'b1;
            own_if_d  = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = if_addr;
            m_wdata_d = '0;
            m_wmask_d = '0;
            starve_d  = '0;
          end else begin
            d_gnt     = 1'b1;
            own_if_d  = 1'b0;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wmask_d = d_wmask;
            if (!if_req) begin
              starve_d = '0;
            end else if (starve_q != STARVE_LIM) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end
        end
      end
      S_WAIT_ACC: begin
        // a response before the request was accepted is a protocol violation
        if (m_rvalid) begin
          err_d = 1'b1;
        end
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (m_rvalid) begin
          if (own_if_q) begin
            if_rvalid = 1'b1;
            if_rdata  = m_rdata;
          end else begin
            d_rvalid  = 1'b1;
            d_rdata   = m_rdata;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    hold_if = (if_req && !if_gnt) ||
              (own_if_q && (state_q != S_IDLE) && !if_rvalid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      own_if_q  <= 1'b0;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wmask_q <= '0;
      starve_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_if_q  <= own_if_d;
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wmask_q <= m_wmask_d;
      starve_q  <= starve_d;
      err_q     <= err_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wmask = m_wmask_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. A driver issues requests
// and memory responses cycle by cycle, predicting grants with a high-level
// arbitration model and pushing expected grants, memory requests and responses
// into queues; a monitor on the falling edge pops and compares.

module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [63:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_wmask;
  logic        d_gnt, d_rvalid;
  logic [63:0] d_rdata;
  logic        m_valid, m_we;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wmask;
  logic        m_ready, m_rvalid;
  logic [63:0] m_rdata;
  logic        hold_if, err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .hold_if(hold_if), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } mreq_t;

  typedef struct packed {
    logic        own_if;
    logic [63:0] data;
  } rsp_t;

  bit    exp_gnt_q[$];
  mreq_t exp_mreq_q[$];
  rsp_t  exp_rsp_q[$];
  bit    gnt_log[$];

  int n_chk  = 0;
  int n_pass = 0;

  // requester / model state
  bit          f_pend, d_pend;
  logic [31:0] f_addr_m, d_addr_m;
  logic        d_we_m;
  logic [63:0] d_wdata_m;
  logic [7:0]  d_wmask_m;
  int          starve_m;
  bit          fetch_outst;
  bit          exp_hold;
  bit          chk_on;
  int          cyc, gnt_cyc, rv_cyc;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_evt(input string nm);
    n_chk++;
    $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
  endtask

  // ---------------- monitor ----------------
  bit    mv_act, acc_pend;
  mreq_t held;

  always @(negedge clk) begin
    if (chk_on) begin
      mreq_t mr;
      rsp_t  rs;
      cyc++;
      check("hold_if", 64'(hold_if), 64'(exp_hold));
      if (if_gnt || d_gnt) begin
        gnt_cyc = cyc;
        if (if_gnt && d_gnt) fail_evt("double_gnt");
        else if (exp_gnt_q.size() == 0) fail_evt("gnt_unexpected");
        else begin
          check("gnt_owner", 64'(if_gnt), 64'(exp_gnt_q.pop_front()));
          gnt_log.push_back(if_gnt);
        end
      end
      if (if_rvalid || d_rvalid) begin
        rv_cyc = cyc;
        if (if_rvalid && d_rvalid) fail_evt("double_rvalid");
        else if (exp_rsp_q.size() == 0) fail_evt("rvalid_unexpected");
        else begin
          rs = exp_rsp_q.pop_front();
          check("rsp_owner", 64'(if_rvalid), 64'(rs.own_if));
          check("rsp_data", if_rvalid ? if_rdata : d_rdata, rs.data);
        end
      end
      if (!if_rvalid) check("if_rdata_zero", if_rdata, 64'd0);
      if (!d_rvalid)  check("d_rdata_zero", d_rdata, 64'd0);
      if (acc_pend) begin
        check("m_valid_drop", 64'(m_valid), 64'd0);
        acc_pend = 0;
        mv_act   = 0;
      end else if (m_valid) begin
        if (!mv_act) begin
          mv_act = 1;
          held   = {m_we, m_addr, m_wdata, m_wmask};
          if (exp_mreq_q.size() == 0) fail_evt("m_valid_unexpected");
          else begin
            mr = exp_mreq_q.pop_front();
            check("m_we", 64'(m_we), 64'(mr.we));
            check("m_addr", 64'(m_addr), 64'(mr.addr));
            check("m_wmask", 64'(m_wmask), 64'(mr.wmask));
            if (mr.we) check("m_wdata", m_wdata, mr.wdata);
          end
        end else begin
          check("m_fields_stable", 64'({m_we, m_addr, m_wdata, m_wmask} == held), 64'd1);
        end
        if (m_ready) acc_pend = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_reqs(input int prob);
    if (!f_pend && $urandom_range(99) < prob) begin
      f_pend   = 1;
      f_addr_m = $urandom;
    end
    if (!d_pend && $urandom_range(99) < prob) begin
      d_pend    = 1;
      d_we_m    = 1'($urandom_range(1));
      d_addr_m  = $urandom;
      d_wdata_m = {$urandom, $urandom};
      d_wmask_m = d_we_m ? 8'($urandom) : 8'h00;
    end
  endtask

  task automatic drive_reqs();
    if_req  = f_pend;
    if_addr = f_addr_m;
    d_req   = d_pend;
    d_we    = d_we_m;
    d_addr  = d_addr_m;
    d_wdata = d_wdata_m;
    d_wmask = d_wmask_m;
  endtask

  // One full transaction starting in an IDLE cycle with at least one request pending.
  task automatic do_txn(input int bp, input int lat, input logic [63:0] rd,
                        input bit renew, input bit rv_acc, input bit rst_rsp);
    bit    win_f;
    mreq_t mr;
    rsp_t  rs;
    drive_reqs();
    m_ready  = 1'($urandom_range(1));   // ignored outside WAIT_ACC
    m_rvalid = 1'($urandom_range(1));   // ignored in IDLE
    m_rdata  = {$urandom, $urandom};
    win_f = f_pend && (!d_pend || starve_m == STARVE_MAX);
    exp_gnt_q.push_back(win_f);
    if (win_f) mr = '{we: 1'b0, addr: f_addr_m, wdata: 64'd0, wmask: 8'd0};
    else       mr = '{we: d_we_m, addr: d_addr_m, wdata: d_wdata_m, wmask: d_wmask_m};
    exp_mreq_q.push_back(mr);
    if (win_f)       starve_m = 0;
    else if (f_pend) starve_m = (starve_m + 1 > STARVE_MAX) ? STARVE_MAX : starve_m + 1;
    else             starve_m = 0;
    exp_hold = f_pend && !win_f;
    tick();
    m_rvalid = 0;
    if (win_f) f_pend = 0; else d_pend = 0;
    if (renew) new_reqs(30);
    drive_reqs();
    fetch_outst = win_f;
    for (int k = 0; k < bp; k++) begin
      m_ready  = 0;
      m_rvalid = rv_acc && (k == 0);
      exp_hold = f_pend || fetch_outst;
      tick();
    end
    m_rvalid = 0;
    m_ready  = 1;
    exp_hold = f_pend || fetch_outst;
    tick();
    for (int j = 0; j < lat; j++) begin
      m_ready  = 1'($urandom_range(1));
      m_rvalid = 0;
      exp_hold = f_pend || fetch_outst;
      tick();
    end
    m_ready = 1'($urandom_range(1));
    if (rst_rsp) begin
      rst      = 1;
      m_rvalid = 0;
      exp_hold = f_pend || fetch_outst;
      tick();
      rst         = 0;
      starve_m    = 0;
      fetch_outst = 0;
      f_pend      = 0;
      d_pend      = 0;
      drive_reqs();
      m_rvalid = 1;   // late response after reset must be ignored
      m_rdata  = rd;
      exp_hold = 0;
      #1;
      check("rst_err_clear", 64'(err), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_no_d_rvalid", 64'(d_rvalid), 64'd0);
      check("rst_no_if_rvalid", 64'(if_rvalid), 64'd0);
      tick();
      m_rvalid = 0;
    end else begin
      m_rvalid = 1;
      m_rdata  = rd;
      rs = '{own_if: win_f, data: rd};
      exp_rsp_q.push_back(rs);
      exp_hold = f_pend;
      tick();
      m_rvalid    = 0;
      fetch_outst = 0;
    end
  endtask

  initial begin
    bit exp_seq [6];
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_wmask = 0; m_ready = 0; m_rvalid = 0; m_rdata = 0;
    f_pend = 0; d_pend = 0; f_addr_m = 0; d_addr_m = 0; d_we_m = 0;
    d_wdata_m = 0; d_wmask_m = 0; starve_m = 0; fetch_outst = 0;
    exp_hold = 0; chk_on = 0; cyc = 0; gnt_cyc = 0; rv_cyc = 0;
    repeat (3) tick();
    check("reset_m_valid", 64'(m_valid), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_hold_if", 64'(hold_if), 64'd0);
    check("reset_m_addr", 64'(m_addr), 64'd0);
    rst = 0;
    chk_on = 1;
    tick();

    // fetch read with minimum latency
    f_pend = 1; f_addr_m = 32'h8000_0000;
    do_txn(0, 0, 64'h1234, 0, 0, 0);
    check("fetch_latency", 64'(rv_cyc - gnt_cyc), 64'd2);

    // simultaneous requests: data write first, fetch right after
    gnt_log.delete();
    f_pend = 1; f_addr_m = 32'h0000_2000;
    d_pend = 1; d_we_m = 1; d_addr_m = 32'h100; d_wdata_m = 64'hDEAD_BEEF_0000_0001;
    d_wmask_m = 8'hFF;
    do_txn(1, 1, 64'h0, 0, 0, 0);
    do_txn(0, 0, 64'hABCD, 0, 0, 0);
    check("simul_count", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() == 2) begin
      check("simul_first_data", 64'(gnt_log[0]), 64'd0);
      check("simul_then_fetch", 64'(gnt_log[1]), 64'd1);
    end

    // starvation: fetch held, data reissued continuously
    gnt_log.delete();
    exp_seq = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      if (!f_pend) begin f_pend = 1; f_addr_m = $urandom; end
      new_reqs(100);
      do_txn(0, 1, {$urandom, $urandom}, 0, 0, 0);
    end
    check("starve_count", 64'(gnt_log.size()), 64'd6);
    if (gnt_log.size() == 6)
      for (int i = 0; i < 6; i++) check("starve_seq", 64'(gnt_log[i]), 64'(exp_seq[i]));

    // backpressure for 5 cycles with the other requester waiting
    f_pend = 0; d_pend = 0;
    new_reqs(100);
    do_txn(5, 2, {$urandom, $urandom}, 0, 0, 0);
    if (f_pend || d_pend) do_txn(0, 0, {$urandom, $urandom}, 0, 0, 0);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      new_reqs(60);
      if (!f_pend && !d_pend) begin
        drive_reqs();
        m_ready  = 1'($urandom_range(1));
        m_rvalid = 1'($urandom_range(1));
        m_rdata  = {$urandom, $urandom};
        exp_hold = 0;
        tick();
        m_rvalid = 0;
      end else begin
        do_txn($urandom_range(5), $urandom_range(2), {$urandom, $urandom}, 1, 0, 0);
      end
    end
    check("err_quiet", 64'(err), 64'd0);

    // protocol error: response while still waiting for accept
    while (f_pend || d_pend) do_txn(0, 0, {$urandom, $urandom}, 0, 0, 0);
    d_pend = 1; d_we_m = 0; d_addr_m = 32'h40; d_wmask_m = 0;
    do_txn(2, 0, {$urandom, $urandom}, 0, 1, 0);
    check("err_set", 64'(err), 64'd1);
    d_pend = 1; d_addr_m = 32'h48;
    do_txn(0, 0, {$urandom, $urandom}, 0, 0, 0);
    check("err_sticky", 64'(err), 64'd1);

    // reset while waiting for the response
    d_pend = 1; d_we_m = 0; d_addr_m = 32'h80; d_wmask_m = 0;
    do_txn(0, 1, 64'h5555, 0, 0, 1);
    f_pend = 1; f_addr_m = 32'h300;
    do_txn(1, 0, 64'h7777, 0, 0, 0);

    drive_reqs();
    exp_hold = 0;
    repeat (2) tick();
    check("gnt_q_empty", 64'(exp_gnt_q.size()), 64'd0);
    check("mreq_q_empty", 64'(exp_mreq_q.size()), 64'd0);
    check("rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 64: data width; byte mask width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_MAX, default 4: consecutive data grants tolerated while fetch waits.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data-side request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_wmask  in  DATA_W/8  byte write mask.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  read data valid or write acknowledged.
- d_rdata  out  DATA_W  data read result.
- m_valid  out  1  memory request valid.
- m_we, m_addr, m_wdata, m_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  memory request fields.
- m_ready  in  1  memory accepts request.
- m_rvalid  in  1  memory response (read data or write ack).
- m_rdata  in  DATA_W  memory read data.
- hold_if  out  1  stall for fetch stage.
- err  out  1  sticky protocol error.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT_ACC, WAIT_RSP, with only one outstanding memory transaction.
REQ-006 In IDLE, with any request present, SHALL select an owner, assert that owner's gnt combinationally in the same cycle, latch owner, we, addr, wdata and wmask, then enter WAIT_ACC.
REQ-007 Arbitration SHALL give data priority over fetch, except that fetch SHALL win when both request and the starvation count equals STARVE_MAX.
REQ-008 The starvation count SHALL be a saturating counter:
- +1 on a data grant while if_req=1.
- cleared on any fetch grant.
- cleared on a data grant while if_req=0.
REQ-009 A fetch transaction SHALL drive m_we=0 and m_wmask=0.
REQ-010 m_valid and the m_* request fields SHALL be registered, asserted from the cycle after the grant, and held stable until the m_ready cycle.
REQ-011 In WAIT_ACC, m_ready=1 SHALL drop m_valid on the next cycle and move the FSM to WAIT_RSP.
REQ-012 In WAIT_RSP, m_rvalid=1 SHALL assert the owner's rvalid combinationally in the same cycle, pass m_rdata through to the owner's rdata, and return the FSM to IDLE.
REQ-013 The non-owner's rvalid SHALL stay 0, and both rdata outputs SHALL be 0 whenever the corresponding rvalid is 0.
REQ-014 Minimum transaction latency SHALL be 2 cycles from gnt to rvalid; the next grant occurs no earlier than the cycle after rvalid.
REQ-015 Requests arriving outside IDLE SHALL be ignored (no gnt); requesters hold req until gnt.
REQ-016 hold_if SHALL be 1 when either:
- if_req=1 and if_gnt=0, or
- a fetch transaction is outstanding (WAIT_ACC/WAIT_RSP) and if_rvalid=0.
REQ-017 m_rvalid=1 in WAIT_ACC SHALL set err, which stays 1 until reset; m_rvalid in IDLE SHALL be ignored.
REQ-018 m_ready outside WAIT_ACC SHALL be ignored.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE, zero the starvation count, clear err, and drive all registered outputs to 0.
REQ-020 Reset mid-transaction SHALL abandon it: no rvalid is issued, m_valid=0 from the cycle after reset, and a late m_rvalid is ignored.

Verification
REQ-021 Fetch read: if_req=1, if_addr=0x80000000 with m_ready=1 at cycle 1 and m_rvalid=1 with m_rdata=0x1234 at cycle 2 -> if_gnt at cycle 0, m_addr=0x80000000 at cycle 1, if_rvalid with if_rdata=0x1234 at cycle 2.
REQ-022 Simultaneous requests: if_req=1, d_req=1, d_we=1, d_addr=0x100, d_wmask=0xFF -> d_gnt first with m_we=1; if_gnt in the IDLE cycle after d_rvalid; hold_if=1 throughout.
REQ-023 Starvation: if_req held at 1 while d_req is reissued continuously -> exactly 4 data grants, then if_gnt, then the count is 0.
REQ-024 Backpressure: m_ready=0 for 5 cycles -> m_valid and m_addr stay stable and no gnt is issued; m_ready=1 -> WAIT_RSP.
REQ-025 Protocol/reset: m_rvalid in WAIT_ACC -> err=1 persistent; rst during WAIT_RSP -> no rvalid, m_valid=0, err=0 next cycle.
